// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the commit-trace buffer
//
// Purpose: FSM state encoding, the stored trace entry layout and the drop
//          counter width used by commit_trace_buf and trace_fifo.
// Macro:   COMMIT_TRACE_RF_EN adds the register-file write fields to each
//          entry (102-bit entry); without it an entry is pc+inst (64 bits).
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_t;

  localparam int TRACE_DROP_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
`ifdef COMMIT_TRACE_RF_EN
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO holding trace entries
//
// Purpose: DEPTH-entry FWFT FIFO. A push while full is accepted only when a
//          pop happens in the same cycle; the head is presented
//          combinationally from storage and forced to zero when empty.
// Ports:   clk, rst        - clock, asynchronous active-high reset
//          wr_en, wr_data  - push request and data
//          wr_ok           - push would be accepted this cycle
//          rd_en           - consumer ready; pops when rd_valid is also 1
//          rd_valid        - head entry present (count != 0)
//          rd_data         - head entry, zero when empty
//          count           - occupancy, 0..DEPTH
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ok,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid && rd_en;
  // A full FIFO still takes a push when the head leaves at the same edge.
  assign wr_ok    = (count != FULL_CNT) || do_pop;
  assign do_push  = wr_en && wr_ok;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// rtl/commit_trace_buf.sv - commit-trace capture buffer for the single-cycle CPU
//
// Purpose: records retired instructions (rebased PC, instruction word and,
//          with COMMIT_TRACE_RF_EN defined, the register-file write) into a
//          FWFT FIFO drained over a valid/ready stream. Capture starts on
//          arm, optionally waiting for a trigger PC, and ends on stop.
// Macro:   COMMIT_TRACE_RF_EN - store and output the RF write fields; when
//          undefined out_rf_* are tied to 0 and the ports remain.
// Ports:   clk_in, reset               - clock, asynchronous active-high reset
//          commit_*                    - retiring instruction from the core
//          arm, stop                   - session control pulses
//          trig_en, trig_pc            - trigger enable (sampled on arm), address
//          out_valid, out_ready        - drain handshake
//          out_pc/inst/rf_we/rf_addr/rf_wdata - head entry fields
//          state, count, drop_cnt      - FSM state, occupancy, overflow losses
module commit_trace_buf
  import trace_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] PC_BASE = 32'h00400000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    commit_valid,
  input  logic [31:0]             commit_pc,
  input  logic [31:0]             commit_inst,
  input  logic                    commit_rf_we,
  input  logic [4:0]              commit_rf_addr,
  input  logic [31:0]             commit_rf_wdata,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    trig_en,
  input  logic [31:0]             trig_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  output logic                    out_rf_we,
  output logic [4:0]              out_rf_addr,
  output logic [31:0]             out_rf_wdata,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count,
  output logic [TRACE_DROP_W-1:0] drop_cnt
);

  localparam int EW = $bits(trace_entry_t);

  trace_state_t st;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic [31:0]  rebased_pc;
  logic         want_push;
  logic         push_ok;

  assign rebased_pc = commit_pc + PC_BASE;

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = rebased_pc;
    wr_entry.inst = commit_inst;
`ifdef COMMIT_TRACE_RF_EN
    wr_entry.rf_we    = commit_rf_we;
    wr_entry.rf_addr  = commit_rf_addr;
    wr_entry.rf_wdata = commit_rf_wdata;
`endif
  end

  // stop wins over a same-cycle commit; in ARMED only the trigger commit
  // is captured, and it is the first entry of the session.
  always_comb begin
    want_push = 1'b0;
    if (commit_valid && !stop) begin
      case (st)
        ST_CAPTURE: want_push = 1'b1;
        ST_ARMED:   want_push = (rebased_pc == trig_pc);
        default:    want_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      st       <= ST_IDLE;
      drop_cnt <= '0;
    end else begin
      if (want_push && !push_ok && (drop_cnt != '1))
        drop_cnt <= drop_cnt + TRACE_DROP_W'(1);
      case (st)
        ST_IDLE, ST_STOPPED: begin
          if (arm) begin
            st       <= trig_en ? ST_ARMED : ST_CAPTURE;
            drop_cnt <= '0;
          end
        end
        ST_ARMED: begin
          if (stop)           st <= ST_STOPPED;
          else if (want_push) st <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stop) st <= ST_STOPPED;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk_in),
    .rst      (reset),
    .wr_en    (want_push),
    .wr_data  (wr_entry),
    .wr_ok    (push_ok),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rd_entry),
    .count    (count)
  );

  assign state    = st;
  assign out_pc   = rd_entry.pc;
  assign out_inst = rd_entry.inst;

`ifdef COMMIT_TRACE_RF_EN
  assign out_rf_we    = rd_entry.rf_we;
  assign out_rf_addr  = rd_entry.rf_addr;
  assign out_rf_wdata = rd_entry.rf_wdata;
`else
  logic unused_rf;
  assign unused_rf    = ^{commit_rf_we, commit_rf_addr, commit_rf_wdata};
  assign out_rf_we    = 1'b0;
  assign out_rf_addr  = 5'd0;
  assign out_rf_wdata = 32'd0;
`endif

endmodule
